// File: rtl/amplitude_scaler_pkg.sv
// Shared constants and types for the amplitude scaler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the board-level defaults (ROM sample width, DAC full scale) and the
// ramp FSM state encoding used by amplitude_ramp.

`ifndef ROM_AMPLITUDE_BIT
`define ROM_AMPLITUDE_BIT 8
`endif

`ifndef DAC_FULL_SCALE_MV
`define DAC_FULL_SCALE_MV 3300
`endif

package amplitude_scaler_pkg;

   localparam int ROM_AMPLITUDE_BIT = `ROM_AMPLITUDE_BIT;
   localparam int DAC_FULL_SCALE_MV = `DAC_FULL_SCALE_MV;

   // Ramp FSM encodings.
   localparam logic STATE_HOLD = 1'b0;
   localparam logic STATE_RAMP = 1'b1;

   typedef enum logic {
      HOLD = STATE_HOLD,
      RAMP = STATE_RAMP
   } ramp_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/amplitude_scaler_if.sv
// Sample/control bundle between the waveform ROM side and the DAC driver side.
// Latency: n/a (wires only).
// Backpressure: none; producer presents one sample per cycle at will.
//
// master: drives target amplitude, offset and samples; observes the results.
// slave : the scaler itself.

interface amplitude_scaler_if
   import amplitude_scaler_pkg::*;
#(
   parameter int IN_W  = ROM_AMPLITUDE_BIT,
   parameter int AMP_W = 11,
   parameter int OFS_W = 12,
   parameter int OUT_W = 12
);

   logic [AMP_W-1:0] amplitude_mv;
   logic [OFS_W-1:0] offset_mv;
   logic [IN_W-1:0]  value_in;
   logic             in_valid;
   logic [OUT_W-1:0] value_out;
   logic             out_valid;
   logic             clip;
   logic             ramp_busy;

   modport master (
      output amplitude_mv, offset_mv, value_in, in_valid,
      input  value_out, out_valid, clip, ramp_busy
   );

   modport slave (
      input  amplitude_mv, offset_mv, value_in, in_valid,
      output value_out, out_valid, clip, ramp_busy
   );

endinterface

// File: rtl/amplitude_ramp.sv
// Slews the applied amplitude toward the live target by RAMP_STEP every RAMP_DIV cycles.
// Latency: amp_cur registered; first tick RAMP_DIV cycles after leaving HOLD.
// Backpressure: none; target is sampled every cycle.
//
// Ports: clk, rst (sync, active-high), target_mv (live target),
//        amp_cur (currently applied amplitude), ramp_busy (FSM in RAMP).

module amplitude_ramp
   import amplitude_scaler_pkg::*;
#(
   parameter int AMP_W     = 11,
   parameter int RAMP_STEP = 8,
   parameter int RAMP_DIV  = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AMP_W-1:0] target_mv,
   output logic [AMP_W-1:0] amp_cur,
   output logic             ramp_busy
);

   // RAMP_DIV of 1 still needs a 1-bit counter that ticks every cycle.
   localparam int                CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_DIV - 1);
   localparam logic [AMP_W-1:0]  STEP_MV  = AMP_W'(RAMP_STEP);

   ramp_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [AMP_W-1:0] amp_nxt;
   logic [AMP_W-1:0] diff_mv;
   logic [AMP_W-1:0] move_mv;
   logic             going_up;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= HOLD;
         cnt     <= '0;
         amp_cur <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         amp_cur <= amp_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      amp_nxt   = amp_cur;

      // Direction and step size are always taken against the live target,
      // and the last step is clipped so the ramp lands exactly on it.
      going_up = (target_mv > amp_cur);
      diff_mv  = going_up ? (target_mv - amp_cur) : (amp_cur - target_mv);
      move_mv  = (diff_mv < STEP_MV) ? diff_mv : STEP_MV;

      case (state)
         HOLD: begin
            cnt_nxt = '0;
            if (target_mv != amp_cur) begin
               if (RAMP_STEP == 0) begin
                  amp_nxt = target_mv;
               end else begin
                  state_nxt = RAMP;
               end
            end
         end
         RAMP: begin
            if (target_mv == amp_cur) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               amp_nxt = going_up ? (amp_cur + move_mv) : (amp_cur - move_mv);
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign ramp_busy = (state == RAMP);

endmodule

// File: rtl/amplitude_scaler.sv
// Scales ROM samples by the slewed amplitude, adds a DC offset and saturates to DAC full scale.
// Latency: 2 cycles in_valid -> out_valid (stage 1 capture, stage 2 clamp).
// Backpressure: none; one sample accepted every cycle.
//
// Ports: clk, rst (sync, active-high), bus (slave side of amplitude_scaler_if).
// IN_W/AMP_W/OFS_W/OUT_W must match the widths of the connected interface.

module amplitude_scaler
   import amplitude_scaler_pkg::*;
#(
   parameter int IN_W      = ROM_AMPLITUDE_BIT,
   parameter int AMP_W     = 11,
   parameter int OFS_W     = 12,
   parameter int OUT_W     = 12,
   parameter int OUT_MAX   = DAC_FULL_SCALE_MV,
   parameter int RAMP_STEP = 8,
   parameter int RAMP_DIV  = 256
) (
   input  logic               clk,
   input  logic               rst,
   amplitude_scaler_if.slave  bus
);

   localparam int PROD_W = IN_W + AMP_W;
   localparam int SUM_W  = max_int(AMP_W, OFS_W) + 1;

   logic [AMP_W-1:0]  amp_cur;
   logic              ramp_busy;

   // Stage 1
   logic [IN_W-1:0]   s1_val;
   logic [OFS_W-1:0]  s1_ofs;
   logic [AMP_W-1:0]  s1_amp;
   logic              s1_vld;

   // Stage 2 / outputs
   logic [OUT_W-1:0]  value_out_q;
   logic              clip_q;
   logic              out_valid_q;

   logic [PROD_W-1:0] product;
   logic [AMP_W-1:0]  scaled;
   logic [SUM_W-1:0]  sum;
   logic              sat;

   amplitude_ramp #(
      .AMP_W     (AMP_W),
      .RAMP_STEP (RAMP_STEP),
      .RAMP_DIV  (RAMP_DIV)
   ) u_ramp (
      .clk       (clk),
      .rst       (rst),
      .target_mv (bus.amplitude_mv),
      .amp_cur   (amp_cur),
      .ramp_busy (ramp_busy)
   );

   // amp_cur is a register, so a sample captured on the same edge as a ramp
   // tick picks up the value from before that tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_val <= '0;
         s1_ofs <= '0;
         s1_amp <= '0;
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= bus.in_valid;
         if (bus.in_valid) begin
            s1_val <= bus.value_in;
            s1_ofs <= bus.offset_mv;
            s1_amp <= amp_cur;
         end
      end
   end

   // Sample is a fraction of 2^IN_W; the shift truncates toward zero.
   always_comb begin
      product = PROD_W'(s1_val) * PROD_W'(s1_amp);
      scaled  = AMP_W'(product >> IN_W);
      sum     = SUM_W'(scaled) + SUM_W'(s1_ofs);
      sat     = (sum > SUM_W'(OUT_MAX));
   end

   // Result and clip hold their last valid values through gaps in the stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_out_q <= '0;
         clip_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= s1_vld;
         if (s1_vld) begin
            value_out_q <= sat ? OUT_W'(OUT_MAX) : OUT_W'(sum);
            clip_q      <= sat;
         end
      end
   end

   assign bus.value_out = value_out_q;
   assign bus.clip      = clip_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ramp_busy = ramp_busy;

endmodule

// File: tb/tb_amplitude_scaler.sv
// Directed bench for amplitude_scaler with a cycle-level reference model.
// A ramped build (step 10, divide 4) and an immediate-update build (step 0)
// run side by side from one clock and reset.

module tb_amplitude_scaler;

   localparam int IN_W  = 8;
   localparam int AMP_W = 11;
   localparam int OFS_W = 12;
   localparam int OUT_W = 12;
   localparam int OMAX  = 3300;
   localparam int STEP  = 10;
   localparam int DIV   = 4;

   logic clk;
   logic rst;

   amplitude_scaler_if #(.IN_W(IN_W), .AMP_W(AMP_W), .OFS_W(OFS_W), .OUT_W(OUT_W)) bus ();
   amplitude_scaler_if #(.IN_W(IN_W), .AMP_W(AMP_W), .OFS_W(OFS_W), .OUT_W(OUT_W)) bus0 ();

   amplitude_scaler #(
      .IN_W(IN_W), .AMP_W(AMP_W), .OFS_W(OFS_W), .OUT_W(OUT_W),
      .OUT_MAX(OMAX), .RAMP_STEP(STEP), .RAMP_DIV(DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   amplitude_scaler #(
      .IN_W(IN_W), .AMP_W(AMP_W), .OFS_W(OFS_W), .OUT_W(OUT_W),
      .OUT_MAX(OMAX), .RAMP_STEP(0), .RAMP_DIV(DIV)
   ) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Reference model: amplitude as a ramp that moves every DIV-th cycle
   // since it started, and a two-deep list of expected results.
   // ---------------------------------------------------------------------
   bit started = 0;
   int m_amp, m_age;
   bit m_busy;
   int m0_amp;
   bit p1_vld, p1_clip;
   int p1_res;
   bit m_ov, m_clip;
   int m_out;

   initial begin
      forever begin
         @(posedge clk);
         started = 1;
         if (rst) begin
            m_amp = 0; m_age = 0; m_busy = 0; m0_amp = 0;
            p1_vld = 0; p1_res = 0; p1_clip = 0;
            m_ov = 0; m_out = 0; m_clip = 0;
         end else begin
            int s, tgt, d, mv;
            if (p1_vld) begin
               m_out  = p1_res;
               m_clip = p1_clip;
            end
            m_ov   = p1_vld;
            p1_vld = bus.in_valid;
            if (bus.in_valid) begin
               s       = (int'(bus.value_in) * m_amp) / (1 << IN_W) + int'(bus.offset_mv);
               p1_clip = (s > OMAX);
               p1_res  = p1_clip ? OMAX : s;
            end
            tgt = int'(bus.amplitude_mv);
            if (!m_busy) begin
               if (tgt != m_amp) begin
                  m_busy = 1;
                  m_age  = 0;
               end
            end else if (tgt == m_amp) begin
               m_busy = 0;
            end else begin
               m_age++;
               if (m_age % DIV == 0) begin
                  d  = tgt - m_amp;
                  mv = (d > 0) ? d : -d;
                  if (mv > STEP) mv = STEP;
                  m_amp = (d > 0) ? m_amp + mv : m_amp - mv;
               end
            end
            m0_amp = int'(bus0.amplitude_mv);
         end
      end
   end

   // Every-cycle comparison, half a period after the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("out_valid",  int'(bus.out_valid), int'(m_ov));
            chk("value_out",  int'(bus.value_out), m_out);
            chk("clip",       int'(bus.clip),      int'(m_clip));
            chk("ramp_busy",  int'(bus.ramp_busy), int'(m_busy));
            chk("amp_cur",    int'(dut.u_ramp.amp_cur), m_amp);
            chk("amp0_cur",   int'(dut0.u_ramp.amp_cur), m0_amp);
            chk("ramp0_busy", int'(bus0.ramp_busy), 0);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ---------------------------------------------------------------------
   int seq[$];

   task automatic wait_idle(input int maxc);
      int n = 0;
      repeat (2) @(negedge clk);
      while (bus.ramp_busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("ramp settles", int'(bus.ramp_busy), 0);
   endtask

   task automatic collect(input int maxc);
      int last = int'(dut.u_ramp.amp_cur);
      int n = 0;
      seq.delete();
      do begin
         @(negedge clk);
         n++;
         if (int'(dut.u_ramp.amp_cur) != last) seq.push_back(int'(dut.u_ramp.amp_cur));
         last = int'(dut.u_ramp.amp_cur);
      end while ((n < 2 || bus.ramp_busy) && n < maxc);
      chk("collect settles", int'(bus.ramp_busy), 0);
   endtask

   task automatic send(input string name, input int val, input int ofs,
                       input int exp_val, input int exp_clip);
      bus.value_in  = IN_W'(val);
      bus.offset_mv = OFS_W'(ofs);
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({name, " not yet valid"}, int'(bus.out_valid), 0);
      @(negedge clk);
      chk({name, " out_valid"}, int'(bus.out_valid), 1);
      chk({name, " value"},     int'(bus.value_out), exp_val);
      chk({name, " clip"},      int'(bus.clip),      exp_clip);
   endtask

   initial begin
      int exp_down[6];
      int n;
      exp_down = '{90, 80, 70, 60, 50, 45};

      rst = 1'b1;
      bus.amplitude_mv = 11'd100;
      bus.offset_mv    = '0;
      bus.value_in     = '0;
      bus.in_valid     = 1'b0;
      bus0.amplitude_mv = '0;
      bus0.offset_mv    = '0;
      bus0.value_in     = '0;
      bus0.in_valid     = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset value_out", int'(bus.value_out), 0);
      chk("reset out_valid", int'(bus.out_valid), 0);
      chk("reset clip",      int'(bus.clip),      0);
      chk("reset busy",      int'(bus.ramp_busy), 0);

      // Soft start 0 -> 100.
      rst = 1'b0;
      @(negedge clk);
      chk("soft start busy", int'(bus.ramp_busy), 1);
      chk("soft start amp",  int'(dut.u_ramp.amp_cur), 0);
      repeat (39) @(negedge clk);
      chk("amp at 39", int'(dut.u_ramp.amp_cur), 90);
      @(negedge clk);
      chk("amp at 40", int'(dut.u_ramp.amp_cur), 100);
      chk("busy at 40", int'(bus.ramp_busy), 1);
      @(negedge clk);
      chk("busy at 41", int'(bus.ramp_busy), 0);

      // Scaling and saturation at amplitude 1650.
      bus.amplitude_mv = 11'd1650;
      wait_idle(1000);
      chk("amp 1650", int'(dut.u_ramp.amp_cur), 1650);
      send("full scale",   255, 0,    1643, 0);
      send("zero sample",  0,   0,    0,    0);
      send("half sample",  128, 0,    825,  0);
      send("over ceiling", 255, 2000, 3300, 1);
      send("at ceiling",   255, 1657, 3300, 0);
      @(negedge clk);
      chk("hold out_valid", int'(bus.out_valid), 0);
      chk("hold value",     int'(bus.value_out), 3300);

      // 100 -> 45 with a short final step.
      bus.amplitude_mv = 11'd100;
      wait_idle(1000);
      bus.amplitude_mv = 11'd45;
      collect(200);
      chk("down seq len", seq.size(), 6);
      for (int i = 0; i < 6 && i < seq.size(); i++) chk("down seq", seq[i], exp_down[i]);

      // Reverse mid-ramp at 60 -> 70.
      bus.amplitude_mv = 11'd100;
      wait_idle(1000);
      bus.amplitude_mv = 11'd45;
      n = 0;
      while (int'(dut.u_ramp.amp_cur) != 60 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reached 60", int'(dut.u_ramp.amp_cur), 60);
      bus.amplitude_mv = 11'd70;
      collect(200);
      chk("reverse seq len", seq.size(), 1);
      if (seq.size() > 0) chk("reverse seq", seq[0], 70);
      chk("reverse final", int'(dut.u_ramp.amp_cur), 70);

      // Immediate-update build.
      bus0.amplitude_mv = 11'd1000;
      @(negedge clk);
      chk("step0 amp", int'(dut0.u_ramp.amp_cur), 1000);
      chk("step0 busy", int'(bus0.ramp_busy), 0);
      @(negedge clk);
      chk("step0 busy later", int'(bus0.ramp_busy), 0);

      // Continuous stream with a reset pulse mid-ramp.
      bus.amplitude_mv = 11'd500;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 13) begin
            chk("rst value_out", int'(bus.value_out), 0);
            chk("rst out_valid", int'(bus.out_valid), 0);
            chk("rst clip",      int'(bus.clip),      0);
            chk("rst busy",      int'(bus.ramp_busy), 0);
            chk("rst amp",       int'(dut.u_ramp.amp_cur), 0);
         end
         if (i == 14) begin
            chk("restart busy",      int'(bus.ramp_busy), 1);
            chk("restart out_valid", int'(bus.out_valid), 0);
         end
         if (i == 15) begin
            chk("restart first out", int'(bus.out_valid), 1);
            chk("restart value",     int'(bus.value_out), 650);
         end
         if (i == 18) chk("restart first tick", int'(dut.u_ramp.amp_cur), 10);
         bus.value_in  = IN_W'(i * 8 + 3);
         bus.offset_mv = OFS_W'(i * 50);
         bus.in_valid  = 1'b1;
         if (i == 12) rst = 1'b1;
         if (i == 13) rst = 1'b0;
      end
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/amplitude_scaler.md
# amplitude_scaler

Parametrised, pipelined amplitude and offset stage between the waveform ROM and the DAC driver. It multiplies each valid ROM sample by an internally slewed amplitude (mV), adds a DC offset (mV) and saturates to the DAC full scale. A flag reports any clipped sample. Amplitude changes are ramped at a programmable rate, so a new setting never produces a step discontinuity at the DAC.

## Interface
Parameters:
- IN_W, default `ROM_AMPLITUDE_BIT: ROM sample width; samples are unsigned, scale factor is 2^IN_W.
- AMP_W, default 11: amplitude/target width, in mV.
- OFS_W, default 12: offset width, in mV, unsigned.
- OUT_W, default 12: output width.
- OUT_MAX, default `DAC_FULL_SCALE_MV (3300): saturation ceiling, must be < 2^OUT_W.
- RAMP_STEP, default 8: mV per ramp tick; 0 means immediate update (no ramp).
- RAMP_DIV, default 256: clock cycles per ramp tick, ≥ 1.

Ports:
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: reset, synchronous, active-high.
- amplitude_mv  in  AMP_W: target amplitude, sampled every cycle.
- offset_mv  in  OFS_W: DC offset, sampled with each valid sample.
- value_in  in  IN_W: ROM sample.
- in_valid  in  1: value_in is valid this cycle.
- value_out  out  OUT_W: scaled, offset, clamped sample.
- out_valid  out  1: value_out is valid this cycle.
- clip  out  1: value_out was saturated; valid only together with out_valid.
- ramp_busy  out  1: current amplitude differs from the target (state RAMP).

## Operation
- Reset values: value_out=0, out_valid=0, clip=0, ramp_busy=0. amp_cur=0, state HOLD, tick counter=0. After reset the amplitude soft-starts from 0 toward amplitude_mv.
- Ramp FSM, states HOLD and RAMP:
  - HOLD: counter is held at 0. If amplitude_mv != amp_cur and RAMP_STEP=0, load amp_cur=amplitude_mv directly and stay in HOLD. If amplitude_mv != amp_cur and RAMP_STEP>0, go to RAMP.
  - RAMP: counter increments each cycle. When counter==RAMP_DIV-1, a tick occurs and counter goes to 0.
  - On a tick, amp_cur moves toward the current amplitude_mv by min(RAMP_STEP, |amplitude_mv−amp_cur|). The move never overshoots.
  - In RAMP, if amp_cur==amplitude_mv at any cycle, go to HOLD and clear counter. This also applies when the target moves back mid-ramp.
- Target changed mid-ramp: the direction is re-evaluated at every tick against the live amplitude_mv. The counter is not restarted.
- Datapath, with amp_cur captured in stage 1:
  - product = value_in*amp_cur, width IN_W+AMP_W.
  - scaled = product >> IN_W (truncation).
  - sum = scaled + offset_mv, width max(AMP_W,OFS_W)+1.
  - If sum > OUT_MAX: value_out=OUT_MAX and clip=1. Otherwise value_out=sum and clip=0.
- in_valid=0: the pipeline advances and out_valid goes 0 two cycles later. value_out and clip hold their last valid values.
- No backpressure: the block accepts one sample per cycle, every cycle.

## Timing
- Latency is exactly 2 cycles, in_valid → out_valid.
  - Stage 1 registers value_in, offset_mv, amp_cur and valid.
  - Stage 2 registers the clamped result, clip and valid.
- The amplitude applied to a sample is the amp_cur value at the edge where that sample is captured.
- An amp_cur update and a sample capture on the same edge: the sample uses the pre-update value.
- First ramp tick occurs RAMP_DIV cycles after entering RAMP.
- ramp_busy asserts the cycle after the target differs from amp_cur. It deasserts the cycle after amp_cur reaches the target.
- rst asserted mid-ramp or mid-stream: all state returns to reset values on that edge. In-flight samples are discarded, and out_valid is 0 on the following cycle.

## Structure
- config.vh gains DAC_FULL_SCALE_MV (3300). ROM_AMPLITUDE_BIT stays the shared source of IN_W. The state encodings HOLD/RAMP are localparams.
- Sub-module amplitude_ramp holds the FSM, tick counter and amp_cur register, and outputs amp_cur and ramp_busy. The top level holds the 2-stage datapath.

## Test plan
Bench config: IN_W=8, RAMP_STEP=10, RAMP_DIV=4, OUT_MAX=3300.
- Release reset with amplitude_mv=100 → ramp_busy=1, amp_cur steps 10,20,…,100. amp_cur reaches 100 exactly 40 cycles after RAMP entry, and ramp_busy=0 one cycle later.
- amp_cur=1650, offset=0, value_in=255 with in_valid → value_out=1643, clip=0, out_valid exactly 2 cycles later. value_in=0 → value_out=0.
- amp_cur=1650, offset=2000, value_in=255 → sum 3643, value_out=3300, clip=1. With offset=1657 → value_out=3300, clip=0.
- Target 100→45 in HOLD → amp_cur steps 90,80,…,50,45 with the final step 5. Reverse the target to 70 mid-ramp at amp_cur=60 → amp_cur steps to 70, then HOLD.
- RAMP_STEP=0 build, target 1000 → amp_cur=1000 one cycle later, ramp_busy stays 0.
- Continuous in_valid stream with a rst pulse mid-ramp → outputs equal reset values the next cycle, no stale out_valid, soft-start restarts from 0.
